// File: rtl/filter_ctrl_pkg.sv
// Shared types for the filter scratchpad sequencer.
package filter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SP_READ_LATENCY = 1;

endpackage

// File: rtl/filter_addr_gen.sv
// Replay address generator: base + element index, with element and window counters.
module filter_addr_gen #(
    parameter int AW = 8,
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic [AW-1:0] base_in,
    input  logic [AW-1:0] len,
    input  logic [WW-1:0] nwin,
    input  logic          adv,
    output logic [AW-1:0] read_addr,
    output logic          last_elem,
    output logic          last_window
);

    logic [AW-1:0] base_q;
    logic [AW-1:0] ecnt_q;
    logic [WW-1:0] widx_q;
    logic [AW-1:0] addr_q;

    assign last_elem   = (ecnt_q == len - AW'(1));
    assign last_window = (widx_q == nwin - WW'(1));
    assign read_addr   = addr_q;

    // addr_q tracks base + ecnt so the address leaves this block straight from a flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            ecnt_q <= '0;
            widx_q <= '0;
            addr_q <= '0;
        end else if (capture) begin
            base_q <= base_in;
            ecnt_q <= '0;
            widx_q <= '0;
            addr_q <= base_in;
        end else if (adv) begin
            if (last_elem) begin
                ecnt_q <= '0;
                widx_q <= widx_q + WW'(1);
                addr_q <= base_q;
            end else begin
                ecnt_q <= ecnt_q + AW'(1);
                addr_q <= addr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/filter_scratch_ctrl.sv
// Filter scratchpad sequencer: loads a filter from the input stream, then replays it
// once per output window toward the PE.
//
//  state | meaning
//  IDLE  | waiting for start; job parameters latched on start
//  LOAD  | accepting filter words into the scratchpad
//  READ  | replaying the filter, gated by pe_ready
//  DONE  | one-cycle job-end pulse
module filter_scratch_ctrl #(
    parameter int SCRATCH_ADDRESS_SIZE = 8,
    parameter int WINDOW_CNT_WIDTH     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] filter_len,
    input  logic [WINDOW_CNT_WIDTH-1:0]     num_windows,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            write_en,
    output logic                            cnt,
    output logic                            chip_en,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] last_write,
    output logic                            read_en,
    output logic [SCRATCH_ADDRESS_SIZE-1:0] read_addr,
    input  logic                            pe_ready,
    output logic                            sp_valid,
    output logic                            window_done,
    output logic                            busy,
    output logic                            done
);
    import filter_ctrl_pkg::*;

    localparam int SAS = SCRATCH_ADDRESS_SIZE;
    localparam int WCW = WINDOW_CNT_WIDTH;

    state_t                       state_q, state_d;
    logic [SAS-1:0]               len_q;
    logic [SAS-1:0]               wcnt_q;
    logic [WCW-1:0]               nwin_q;
    logic                         done_q;
    logic                         accept;
    logic                         capture;
    logic                         last_elem;
    logic                         last_window;
    logic [SP_READ_LATENCY-1:0]   vld_pipe;
    logic [SP_READ_LATENCY-1:0]   wd_pipe;

    assign busy        = (state_q != IDLE);
    assign chip_en     = busy;
    assign accept      = in_ready & in_valid;
    assign write_en    = accept;
    assign cnt         = accept;
    assign capture     = (state_q == IDLE) & start;
    assign done        = done_q;
    assign sp_valid    = vld_pipe[SP_READ_LATENCY-1];
    assign window_done = wd_pipe[SP_READ_LATENCY-1];

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        read_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (filter_len == '0) ? DONE : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (wcnt_q == len_q - SAS'(1)))
                    state_d = (nwin_q != '0) ? READ : DONE;
            end
            READ: begin
                read_en = pe_ready;
                if (pe_ready && last_elem && last_window) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            nwin_q  <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            if (capture) begin
                len_q  <= filter_len;
                nwin_q <= num_windows;
                wcnt_q <= '0;
            end else if (accept) begin
                wcnt_q <= wcnt_q + SAS'(1);
            end
        end
    end

    // Valid and window-end flags ride alongside the scratchpad read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            wd_pipe  <= '0;
        end else begin
            vld_pipe[0] <= read_en;
            wd_pipe[0]  <= read_en & last_elem;
            for (int i = 1; i < SP_READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                wd_pipe[i]  <= wd_pipe[i-1];
            end
        end
    end

    filter_addr_gen #(
        .AW (SAS),
        .WW (WCW)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .base_in     (last_write),
        .len         (len_q),
        .nwin        (nwin_q),
        .adv         (read_en),
        .read_addr   (read_addr),
        .last_elem   (last_elem),
        .last_window (last_window)
    );

endmodule
